fmllat: RTL

// - FML bus latency probe; sits beside the FML bandwidth meter on the same probed FML master port, CSR-mapped.
// - Measures per-transaction stb-to-ack latency; keeps count, sum, min, max and protocol-violation stats.
// - Optionally stores per-transaction latencies in a capture FIFO drained over CSR.

---
 rtl/fmllat.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fmllat.sv
// fmllat: FML stb-to-ack latency probe with CSR-readable stats; csr_do has 1-cycle latency, and the probe never stalls the bus.
// FMLLAT_CAPTURE_EN adds a per-transaction latency capture FIFO that drops entries on overflow and sets a sticky ovf flag.
module fmllat #(
  parameter logic [3:0] csr_addr        = 4'h0,
  parameter int         fifo_depth_log2 = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  input  logic        fml_stb,
  input  logic        fml_we,
  input  logic        fml_ack
);

  typedef enum logic {IDLE, PENDING} state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic        stb_r, we_r, ack_r;
  state_t      state;
  logic        en;
  logic [15:0] lat, lat_min, lat_max, lat_inc;
  logic [31:0] txn_cnt, lat_sum, wr_cnt, err_cnt, sum_nxt;
  logic [32:0] sum_ext;
  logic        csr_sel, ctrl_wr, fifo_rd;
  logic        comp_vld, err_evt;
  logic [15:0] comp_lat;
  logic        ovf;
  logic [31:0] fifo_word;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      stb_r <= 1'b0;
      we_r  <= 1'b0;
      ack_r <= 1'b0;
    end else begin
      stb_r <= fml_stb;
      we_r  <= fml_we;
      ack_r <= fml_ack;
    end
  end

  assign csr_sel = (csr_a[13:10] == csr_addr);
  assign ctrl_wr = csr_sel & csr_we & (csr_a[2:0] == 3'd0);
  assign fifo_rd = csr_sel & ~csr_we & (csr_a[2:0] == 3'd7);

  assign lat_inc = (lat == 16'hFFFF) ? lat : lat + 16'd1;
  assign sum_ext = {1'b0, lat_sum} + {17'd0, comp_lat};
  assign sum_nxt = sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];

  always_comb begin
    comp_vld = 1'b0;
    comp_lat = 16'd1;
    err_evt  = 1'b0;
    if (en) begin
      case (state)
        IDLE: comp_vld = stb_r & ack_r;
        PENDING: begin
          if (ack_r) begin
            comp_vld = 1'b1;
            comp_lat = lat_inc;
          end else if (!stb_r) begin
            err_evt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A CTRL write overrides any completion or error event in the same cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= IDLE;
      en      <= 1'b0;
      lat     <= 16'd0;
      txn_cnt <= 32'd0;
      lat_sum <= 32'd0;
      lat_min <= 16'hFFFF;
      lat_max <= 16'd0;
      wr_cnt  <= 32'd0;
      err_cnt <= 32'd0;
    end else if (ctrl_wr) begin
      en    <= csr_di[0];
      state <= IDLE;
      lat   <= 16'd0;
      if (csr_di[0]) begin
        txn_cnt <= 32'd0;
        lat_sum <= 32'd0;
        lat_min <= 16'hFFFF;
        lat_max <= 16'd0;
        wr_cnt  <= 32'd0;
        err_cnt <= 32'd0;
      end
    end else begin
      if (en) begin
        case (state)
          IDLE: begin
            if (stb_r) lat <= 16'd1;
            if (stb_r && !ack_r) state <= PENDING;
          end
          PENDING: begin
            lat <= lat_inc;
            if (ack_r || !stb_r) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
      if (comp_vld) begin
        txn_cnt <= sat_inc(txn_cnt);
        lat_sum <= sum_nxt;
        if (we_r) wr_cnt <= sat_inc(wr_cnt);
        if (comp_lat < lat_min) lat_min <= comp_lat;
        if (comp_lat > lat_max) lat_max <= comp_lat;
      end
      if (err_evt) err_cnt <= sat_inc(err_cnt);
    end
  end

`ifdef FMLLAT_CAPTURE_EN
  localparam int AW    = fifo_depth_log2;
  localparam int DEPTH = 1 << fifo_depth_log2;

  logic [16:0]  fifo_mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         fifo_empty, fifo_full, push_req, push, pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop        = fifo_rd & ~fifo_empty;
  assign push_req   = comp_vld & ~ctrl_wr;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = push_req & (~fifo_full | pop);
  assign fifo_word  = fifo_empty ? 32'h8000_0000
                                 : {15'd0, fifo_mem[rd_ptr[AW-1:0]]};

  always_ff @(posedge sys_clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {we_r, comp_lat};
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else if (ctrl_wr && csr_di[0]) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      if (push_req && !push) ovf <= 1'b1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{csr_di[31:1], csr_a[9:3]};
`else
  assign ovf       = 1'b0;
  assign fifo_word = 32'd0;

  logic unused_ok;
  assign unused_ok = ^{csr_di[31:1], csr_a[9:3], fifo_rd} ^ (fifo_depth_log2 != 0);
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      csr_do <= 32'd0;
    end else if (!csr_sel) begin
      csr_do <= 32'd0;
    end else begin
      case (csr_a[2:0])
        3'd0:    csr_do <= {30'd0, ovf, en};
        3'd1:    csr_do <= txn_cnt;
        3'd2:    csr_do <= lat_sum;
        3'd3:    csr_do <= {16'd0, lat_min};
        3'd4:    csr_do <= {16'd0, lat_max};
        3'd5:    csr_do <= wr_cnt;
        3'd6:    csr_do <= err_cnt;
        default: csr_do <= fifo_word;
      endcase
    end
  end

endmodule
